// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text engine.
// Palette, pipeline depth and per-pixel pipeline bundle.
package vga_text_pkg;

  localparam int PIPE = 3;

  // CGA colour order, RGB332 encoded
  localparam logic [7:0] PALETTE [16] = '{
    8'h00, 8'h02, 8'h14, 8'h16,
    8'hA0, 8'hA2, 8'hA8, 8'hB6,
    8'h49, 8'h4B, 8'h5D, 8'h5F,
    8'hE9, 8'hEB, 8'hFD, 8'hFF
  };

  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic       cur;
    logic       half;
    logic [2:0] gx;
    logic [2:0] gy;
  } pix_t;

  localparam pix_t PIX_IDLE = '{
    vis: 1'b0, hs: 1'b1, vs: 1'b1,
    cur: 1'b0, half: 1'b0,
    gx: 3'd0, gy: 3'd0
  };

  function automatic int line_total(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_text_engine_glyph_rom.sv
// 256 glyphs x 8 rows x 8 bits, one-tick registered read.
// Contents are a procedural font: code XOR a one-hot row marker.
module glyph_rom (
  input  logic        clk,
  input  logic        ce,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  always_ff @(posedge clk) begin
    if (ce) data <= addr[10:3] ^ (8'h80 >> addr[2:0]);
  end

endmodule

// File: rtl/vga_text_engine.sv
// VGA text-mode engine: timing, cell fetch, glyph lookup, cursor.
// Three-tick pixel pipeline; sync/bright delayed to match rgb.
module vga_text_engine
  import vga_text_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 16,
  parameter int         FB_BASE      = 'h3000,
  parameter int         CLK_DIV      = 2,
  parameter int         HVIS         = 640,
  parameter int         HFP          = 16,
  parameter int         HSYNC        = 96,
  parameter int         HBP          = 48,
  parameter int         VVIS         = 480,
  parameter int         VFP          = 10,
  parameter int         VSYNC        = 2,
  parameter int         VBP          = 33,
  parameter int         SCALE_LOG2   = 1,
  parameter int         ATTR_MODE    = 0,
  parameter logic [7:0] DEF_FG       = 8'hFF,
  parameter logic [7:0] DEF_BG       = 8'h00,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           mem_data,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  bright,
  output logic [7:0]            rgb,
  output logic                  pix_ce,
  output logic                  frame_start,
  input  logic                  cursor_en,
  input  logic [7:0]            cursor_col,
  input  logic [7:0]            cursor_row
);

  localparam int HTOT = line_total(HVIS, HFP, HSYNC, HBP);
  localparam int VTOT = line_total(VVIS, VFP, VSYNC, VBP);
  localparam int CSH  = 3 + SCALE_LOG2;
  localparam int COLS = HVIS >> CSH;
  localparam int STRIDE =
    (ATTR_MODE != 0) ? COLS : (COLS + 1) / 2;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [11:0] H_LAST = 12'(HTOT - 1);
  localparam logic [11:0] V_LAST = 12'(VTOT - 1);
  localparam logic [11:0] H_VIS  = 12'(HVIS);
  localparam logic [11:0] V_VIS  = 12'(VVIS);
  localparam logic [11:0] HS_ON  = 12'(HVIS + HFP);
  localparam logic [11:0] HS_OFF = 12'(HVIS + HFP + HSYNC);
  localparam logic [11:0] VS_ON  = 12'(VVIS + VFP);
  localparam logic [11:0] VS_OFF = 12'(VVIS + VFP + VSYNC);

  logic [DW-1:0] div;
  logic [11:0]   h, v;

  assign pix_ce = div == DW'(CLK_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset)       div <= '0;
    else if (pix_ce) div <= '0;
    else             div <= div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_ce) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 12'd1;
      end else begin
        h <= h + 12'd1;
      end
    end
  end

  assign frame_start = pix_ce && (h == '0) && (v == '0);

  logic          phase, cur_en_q, cur_ph_q;
  logic [BW-1:0] blink_cnt;
  logic [7:0]    cur_col_q, cur_row_q;

  // Phase is captured with the cursor so a frame never changes mid-way
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 1'b0;
      blink_cnt <= '0;
      cur_en_q  <= 1'b0;
      cur_ph_q  <= 1'b0;
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else if (frame_start) begin
      cur_en_q  <= cursor_en;
      cur_col_q <= cursor_col;
      cur_row_q <= cursor_row;
      cur_ph_q  <= phase;
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic                  vis0, hs0, vs0, cur0;
  logic [7:0]            col0, row0;
  logic [2:0]            gx0, gy0;
  logic [ADDR_WIDTH-1:0] addr0;

  assign vis0 = (h < H_VIS) && (v < V_VIS);
  assign hs0  = !((h >= HS_ON) && (h < HS_OFF));
  assign vs0  = !((v >= VS_ON) && (v < VS_OFF));
  assign col0 = 8'(h >> CSH);
  assign row0 = 8'(v >> CSH);
  assign gx0  = 3'(h >> SCALE_LOG2);
  assign gy0  = 3'(v >> SCALE_LOG2);

  assign cur0 = vis0 && cur_en_q && cur_ph_q &&
                (col0 == cur_col_q) &&
                (row0 == cur_row_q) &&
                (gy0[2:1] == 2'b11);

  assign addr0 = ADDR_WIDTH'(
    FB_BASE + int'(row0) * STRIDE +
    ((ATTR_MODE != 0) ? int'(col0) : int'(col0 >> 1)));

  pix_t s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_out <= ADDR_WIDTH'(FB_BASE);
      s1       <= PIX_IDLE;
    end else if (pix_ce) begin
      if (vis0) addr_out <= addr0;
      s1 <= '{vis: vis0, hs: hs0, vs: vs0,
              cur: cur0, half: col0[0],
              gx: gx0, gy: gy0};
    end
  end

  logic [7:0] glyph, fg1, bg1, fg2, bg2, rom_row;
  logic       vis2, hs2, vs2;
  logic [2:0] gx2;

  assign glyph = (ATTR_MODE != 0 || s1.half) ?
                 mem_data[7:0] : mem_data[15:8];
  assign fg1 = (ATTR_MODE != 0) ?
               PALETTE[mem_data[11:8]] : DEF_FG;
  assign bg1 = (ATTR_MODE != 0) ?
               PALETTE[mem_data[15:12]] : DEF_BG;

  glyph_rom u_rom (
    .clk  (clk),
    .ce   (pix_ce),
    .addr ({glyph, s1.gy}),
    .data (rom_row)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vis2 <= 1'b0;
      hs2  <= 1'b1;
      vs2  <= 1'b1;
      gx2  <= '0;
      fg2  <= '0;
      bg2  <= '0;
    end else if (pix_ce) begin
      vis2 <= s1.vis;
      hs2  <= s1.hs;
      vs2  <= s1.vs;
      gx2  <= s1.gx;
      fg2  <= s1.cur ? bg1 : fg1;
      bg2  <= s1.cur ? fg1 : bg1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      bright <= 1'b0;
      rgb    <= '0;
    end else if (pix_ce) begin
      hsync  <= hs2;
      vsync  <= vs2;
      bright <= vis2;
      if (!vis2)                   rgb <= '0;
      else if (rom_row[3'd7 - gx2]) rgb <= fg2;
      else                         rgb <= bg2;
    end
  end

endmodule

// File: tb/tb_vga_text_engine.sv
// Scoreboard bench: two engines (plain and attribute mode) on
// a reduced raster, checked every pixel tick against a model.
module tb_vga_text_engine;
  import vga_text_pkg::*;

  localparam int HV = 64, HF = 2, HSY = 4, HB = 2;
  localparam int VV = 32, VF = 1, VSY = 2, VB = 1;
  localparam int S = 1, BL = 2, CD = 2;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FR = HT * VT;
  localparam int CW = 8 << S;
  localparam int COLS = HV / CW;
  localparam logic [15:0] BASE = 16'h3000;
  localparam logic [10:0] IDLE = {1'b1, 1'b1, 1'b0, 8'h00};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cursor_en;
  logic [7:0] cursor_col, cursor_row;

  logic [15:0] a0, a1, md0, md1, off0, off1;
  logic hs0, vs0, br0, pc0, fs0;
  logic hs1, vs1, br1, pc1, fs1;
  logic [7:0] rgb0, rgb1;

  logic [15:0] mem0 [4];
  logic [15:0] mem1 [8];

  logic [7:0] pal [16] = '{
    8'h00, 8'h02, 8'h14, 8'h16, 8'hA0, 8'hA2, 8'hA8, 8'hB6,
    8'h49, 8'h4B, 8'h5D, 8'h5F, 8'hE9, 8'hEB, 8'hFD, 8'hFF
  };

  always #5 clk = ~clk;

  assign off0 = a0 - BASE;
  assign off1 = a1 - BASE;
  assign md0 = (off0 < 16'd4) ? mem0[off0[1:0]] : 16'hDEAD;
  assign md1 = (off1 < 16'd8) ? mem1[off1[2:0]] : 16'hDEAD;

  vga_text_engine #(
    .ADDR_WIDTH(16), .FB_BASE('h3000), .CLK_DIV(CD),
    .HVIS(HV), .HFP(HF), .HSYNC(HSY), .HBP(HB),
    .VVIS(VV), .VFP(VF), .VSYNC(VSY), .VBP(VB),
    .SCALE_LOG2(S), .ATTR_MODE(0),
    .DEF_FG(8'hFF), .DEF_BG(8'h00), .BLINK_FRAMES(BL)
  ) u0 (
    .clk(clk), .reset(reset), .mem_data(md0),
    .addr_out(a0), .hsync(hs0), .vsync(vs0),
    .bright(br0), .rgb(rgb0), .pix_ce(pc0),
    .frame_start(fs0), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  vga_text_engine #(
    .ADDR_WIDTH(16), .FB_BASE('h3000), .CLK_DIV(CD),
    .HVIS(HV), .HFP(HF), .HSYNC(HSY), .HBP(HB),
    .VVIS(VV), .VFP(VF), .VSYNC(VSY), .VBP(VB),
    .SCALE_LOG2(S), .ATTR_MODE(1),
    .DEF_FG(8'hFF), .DEF_BG(8'h00), .BLINK_FRAMES(BL)
  ) u1 (
    .clk(clk), .reset(reset), .mem_data(md1),
    .addr_out(a1), .hsync(hs1), .vsync(vs1),
    .bright(br1), .rgb(rgb1), .pix_ce(pc1),
    .frame_start(fs1), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  int tests = 0;
  int fails = 0;
  int mh, mv, fc, l_col, l_row;
  logic l_en, l_ph;
  logic [15:0] ea0, ea1;
  logic [10:0] q0[$];
  logic [10:0] q1[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s h=%0d v=%0d observed=%0h expected=%0h",
             tag, mh, mv, obs, exp);
    end
  endtask

  function automatic logic [10:0] model_px(input int mode);
    int col, row, gx, gy;
    logic [15:0] w;
    logic [7:0] g, fg, bg, t, bits;
    logic hs, vs;
    hs = !(mh >= HV + HF && mh < HV + HF + HSY);
    vs = !(mv >= VV + VF && mv < VV + VF + VSY);
    if (!(mh < HV && mv < VV)) return {hs, vs, 1'b0, 8'h00};
    col = mh / CW;
    row = mv / CW;
    gx = (mh >> S) % 8;
    gy = (mv >> S) % 8;
    if (mode == 0) begin
      w = mem0[row * ((COLS + 1) / 2) + col / 2];
      g = (col % 2 == 0) ? w[15:8] : w[7:0];
      fg = 8'hFF;
      bg = 8'h00;
    end else begin
      w = mem1[row * COLS + col];
      g = w[7:0];
      fg = pal[w[11:8]];
      bg = pal[w[15:12]];
    end
    if (l_en && l_ph && col == l_col &&
        row == l_row && gy >= 6) begin
      t = fg;
      fg = bg;
      bg = t;
    end
    bits = g ^ (8'h80 >> gy);
    return {hs, vs, 1'b1, bits[7 - gx] ? fg : bg};
  endfunction

  function automatic logic [15:0] model_addr(input int mode);
    int stride, c;
    stride = (mode != 0) ? COLS : (COLS + 1) / 2;
    c = (mode != 0) ? mh / CW : mh / (2 * CW);
    return 16'(int'(BASE) + (mv / CW) * stride + c);
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; fc = 0;
    l_en = 1'b0; l_ph = 1'b0; l_col = 0; l_row = 0;
    ea0 = BASE; ea1 = BASE;
    q0.delete(); q1.delete();
    repeat (PIPE) begin
      q0.push_back(IDLE);
      q1.push_back(IDLE);
    end
  endtask

  // Entered just after the edge that precedes a pix_ce cycle
  task automatic tick();
    logic fs;
    logic [10:0] e0, e1;
    @(negedge clk);
    fs = (mh == 0 && mv == 0);
    if (fs) begin
      l_en = cursor_en;
      l_col = int'(cursor_col);
      l_row = int'(cursor_row);
      l_ph = ((fc / BL) % 2) == 1;
      fc++;
    end
    chk("pix_ce0", pc0, 1);
    chk("pix_ce1", pc1, 1);
    chk("frame_start0", fs0, fs);
    chk("frame_start1", fs1, fs);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    chk("out0", {hs0, vs0, br0, rgb0}, e0);
    chk("out1", {hs1, vs1, br1, rgb1}, e1);
    chk("addr0", a0, ea0);
    chk("addr1", a1, ea1);
    q0.push_back(model_px(0));
    q1.push_back(model_px(1));
    if (mh < HV && mv < VV) begin
      ea0 = model_addr(0);
      ea1 = model_addr(1);
    end
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("pix_ce_gap0", pc0, 0);
    chk("pix_ce_gap1", pc1, 0);
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_out0", {hs0, vs0, br0, rgb0, pc0, fs0},
        {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    chk("rst_out1", {hs1, vs1, br1, rgb1, pc1, fs1},
        {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    chk("rst_addr0", a0, BASE);
    chk("rst_addr1", a1, BASE);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
  endtask

  task automatic set_cursor(input logic en,
                            input logic [7:0] c,
                            input logic [7:0] r);
    #1;
    cursor_en = en;
    cursor_col = c;
    cursor_row = r;
  endtask

  initial begin
    mh = 0;
    mv = 0;
    for (int i = 0; i < 4; i++) mem0[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem1[i] = 16'($urandom);
    mem0[0] = 16'h4142;
    mem1[2] = 16'h2E55;
    mem1[5] = 16'h1C41;
    mem1[7] = 16'h4A3C;
    cursor_en = 1'b1;
    cursor_col = 8'd2;
    cursor_row = 8'd0;
    do_reset(3);
    repeat (5 * FR) tick();
    repeat (FR / 2) tick();
    set_cursor(1'b1, 8'd3, 8'd1);
    repeat (FR - FR / 2) tick();
    repeat (FR / 2) tick();
    set_cursor(1'b1, 8'd4, 8'd1);
    repeat (FR - FR / 2) tick();
    repeat (FR) tick();
    repeat (20 * HT + 30) tick();
    do_reset(1);
    repeat (FR + 2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog h=%0d v=%0d", mh, mv);
    $fatal(1, "watchdog expired");
  end

endmodule
